// File: rtl/shared_mem_arbiter.sv
// Two-requester round-robin arbiter for the shared-memory slave port, with read-response routing.
// Optional SHARED_ARB_LOCK_EN adds m1_lock, which keeps requester 1 as the exclusive owner.
module shared_mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic            msoc_clk,
  input  logic            rstn,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
`ifdef SHARED_ARB_LOCK_EN
  input  logic            m1_lock,
`endif
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  input  logic            s_ready,
  output logic            s_ce,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_be,
  input  logic [DW-1:0]   s_rdata
);

  logic               last_grant;
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_owner;
  logic               m0_elig;
  logic               win1;
  logic               grant;

  always_comb begin
    m0_elig = m0_req;
`ifdef SHARED_ARB_LOCK_EN
    // Requester 1 keeps ownership while locked and it was the last winner.
    if (m1_lock && last_grant) m0_elig = 1'b0;
`endif
    win1  = (m0_elig && m1_req) ? ~last_grant : m1_req;
    grant = s_ready & (m0_elig | m1_req);
  end

  always_comb begin
    m0_gnt  = grant & ~win1;
    m1_gnt  = grant & win1;
    s_ce    = grant;
    s_we    = m0_we;
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    s_be    = m0_be;
    if (grant && win1) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_be    = m1_be;
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      if (grant) last_grant <= win1;
      for (int i = int'(LATENCY) - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
      pipe_valid[0] <= grant & ~s_we;
      pipe_owner[0] <= win1;
    end
  end

  always_comb begin
    m0_rvalid = pipe_valid[LATENCY-1] & ~pipe_owner[LATENCY-1];
    m1_rvalid = pipe_valid[LATENCY-1] & pipe_owner[LATENCY-1];
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: three instances (LATENCY 1..3) share stimulus and are checked
// against a round-robin reference model; define SHARED_ARB_LOCK_EN to exercise m1_lock.
module tb_shared_mem_arbiter;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
`ifdef SHARED_ARB_LOCK_EN
  logic        m1_lock;
`endif

  logic        g0 [NI];
  logic        g1 [NI];
  logic        rv0 [NI];
  logic        rv1 [NI];
  logic        sce [NI];
  logic        swe [NI];
  logic [31:0] rd0 [NI];
  logic [31:0] rd1 [NI];
  logic [31:0] saddr [NI];
  logic [31:0] swdata [NI];
  logic [31:0] srdata [NI];
  logic [3:0]  sbe [NI];
  logic [31:0] slv_hist [NI][16];

  int cyc = 100;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    assign srdata[k] = slv_hist[k][4'(cyc - k - 1)];
    shared_mem_arbiter #(.AW(32), .DW(32), .LATENCY(k + 1)) u_dut (
      .msoc_clk (clk),
      .rstn     (rstn),
      .m0_req   (m0_req),
      .m0_we    (m0_we),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_be    (m0_be),
      .m0_gnt   (g0[k]),
      .m0_rvalid(rv0[k]),
      .m0_rdata (rd0[k]),
      .m1_req   (m1_req),
      .m1_we    (m1_we),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_be    (m1_be),
`ifdef SHARED_ARB_LOCK_EN
      .m1_lock  (m1_lock),
`endif
      .m1_gnt   (g1[k]),
      .m1_rvalid(rv1[k]),
      .m1_rdata (rd1[k]),
      .s_ready  (s_ready),
      .s_ce     (sce[k]),
      .s_we     (swe[k]),
      .s_addr   (saddr[k]),
      .s_wdata  (swdata[k]),
      .s_be     (sbe[k]),
      .s_rdata  (srdata[k])
    );
  end

  // Reference model state: last winner and per-cycle record of accepted reads.
  int          last = 1;
  int          hist_own [16];
  logic [31:0] hist_dat [16];
  bit          known = 1'b0;
  int          exp_win;
  int          errors = 0;
  int          checks = 0;

  int          ob_win;
  logic        ob_sce, ob_swe;
  logic [31:0] ob_addr, ob_wdata, ob_rd0;
  logic [3:0]  ob_be;
  logic        ob_rv0 [NI];
  logic        ob_rv1 [NI];
  logic        sl_rd [NI];
  logic [31:0] sl_dat [NI];

  function automatic logic [31:0] memfn(logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic int winner(logic r0, logic r1, logic rdy, int lk, int lst);
    bit e0;
    e0 = r0 && !(lk != 0 && lst == 1);
    if (!rdy) return -1;
    if (e0 && r1) return 1 - lst;
    if (e0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check at the falling edge, advance model and slave at the rising edge.
  task automatic cycle();
    int lk;
    int e;
    int own;
    string p;
    @(negedge clk);
`ifdef SHARED_ARB_LOCK_EN
    lk = int'(m1_lock);
`else
    lk = 0;
`endif
    exp_win = winner(m0_req, m1_req, s_ready, lk, last);
    if (known) begin
      for (int k = 0; k < NI; k++) begin
        p = $sformatf("L%0d_", k + 1);
        check({p, "m0_gnt"}, g0[k], exp_win == 0);
        check({p, "m1_gnt"}, g1[k], exp_win == 1);
        check({p, "s_ce"}, sce[k], exp_win >= 0);
        check({p, "s_we"}, swe[k], (exp_win == 1) ? m1_we : m0_we);
        check({p, "s_addr"}, saddr[k], (exp_win == 1) ? m1_addr : m0_addr);
        check({p, "s_wdata"}, swdata[k], (exp_win == 1) ? m1_wdata : m0_wdata);
        check({p, "s_be"}, sbe[k], (exp_win == 1) ? m1_be : m0_be);
        e = hist_own[(cyc - k - 1) & 15];
        check({p, "m0_rvalid"}, rv0[k], e == 0);
        check({p, "m1_rvalid"}, rv1[k], e == 1);
        if (e == 0) check({p, "m0_rdata"}, rd0[k], hist_dat[(cyc - k - 1) & 15]);
        if (e == 1) check({p, "m1_rdata"}, rd1[k], hist_dat[(cyc - k - 1) & 15]);
      end
    end
    ob_win   = g0[0] ? 0 : (g1[0] ? 1 : -1);
    ob_sce   = sce[0];
    ob_swe   = swe[0];
    ob_addr  = saddr[0];
    ob_wdata = swdata[0];
    ob_be    = sbe[0];
    ob_rd0   = rd0[0];
    for (int k = 0; k < NI; k++) begin
      ob_rv0[k] = rv0[k];
      ob_rv1[k] = rv1[k];
      sl_rd[k]  = sce[k] & ~swe[k];
      sl_dat[k] = memfn(saddr[k]);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) slv_hist[k][4'(cyc)] = sl_rd[k] ? sl_dat[k] : 32'h0BAD0000;
    own = -1;
    if (exp_win >= 0 && !((exp_win == 1) ? m1_we : m0_we)) own = exp_win;
    if (!rstn) begin
      last  = 1;
      known = 1'b1;
      for (int i = 0; i < 16; i++) hist_own[i] = -1;
    end else begin
      if (exp_win >= 0) last = exp_win;
      hist_own[cyc & 15] = own;
      hist_dat[cyc & 15] = memfn((exp_win == 1) ? m1_addr : m0_addr);
    end
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    s_ready = 1;
`ifdef SHARED_ARB_LOCK_EN
    m1_lock = 0;
`endif
  endtask

  task automatic do_reset();
    rstn = 0;
    cycle();
    rstn = 1;
  endtask

  task automatic rand_m0();
    m0_req = ($urandom % 3) != 0; m0_we = ($urandom % 3) == 0;
    m0_addr = $urandom & 32'hFFF; m0_wdata = $urandom; m0_be = 4'($urandom);
  endtask

  task automatic rand_m1();
    m1_req = ($urandom % 3) != 0; m1_we = ($urandom % 3) == 0;
    m1_addr = $urandom & 32'hFFF; m1_wdata = $urandom; m1_be = 4'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) hist_own[i] = -1;
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 16; i++) slv_hist[k][i] = 32'h0;
    set_idle();
    @(posedge clk);
    #1;
    rstn = 0;
    repeat (3) cycle();
    rstn = 1;

    // Lone m0 read of 0x100.
    m0_req = 1; m0_addr = 32'h100;
    cycle();
    check("t1_gnt", ob_win, 0);
    check("t1_sce", ob_sce, 1);
    check("t1_addr", ob_addr, 32'h100);
    m0_req = 0;
    cycle();
    check("t1_rvalid", ob_rv0[0], 1);
    check("t1_rdata", ob_rd0, 32'hDEADBEEF);
    check("t1_m1_rvalid", ob_rv1[0], 0);
    repeat (3) cycle();

    // Continuous contention from reset alternates starting with m0.
    do_reset();
    m0_req = 1; m0_addr = 32'h200; m1_req = 1; m1_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("t2_order%0d", i), ob_win, i % 2);
      if (exp_win == 0) m0_addr += 1;
      if (exp_win == 1) m1_addr += 1;
    end
    set_idle();
    repeat (4) cycle();

    // m1 partial write while m0 idles.
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h12345678; m1_be = 4'h3;
    cycle();
    check("t3_swe", ob_swe, 1);
    check("t3_sbe", ob_be, 4'h3);
    check("t3_swdata", ob_wdata, 32'h12345678);
    check("t3_addr", ob_addr, 32'h40);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_no_rvalid", {ob_rv0[0], ob_rv1[0], ob_rv0[2], ob_rv1[2]}, 0);
    end

    // Stall with both requesting while an earlier read is in flight.
    m0_req = 1; m0_addr = 32'h180;
    cycle();
    m0_addr = 32'h184; m1_req = 1; m1_addr = 32'h384; s_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_stall_sce", ob_sce, 0);
      check("t4_stall_gnt", ob_win, -1);
      if (i == 0) check("t4_l1_rvalid", ob_rv0[0], 1);
      if (i == 2) check("t4_l3_rvalid", ob_rv0[2], 1);
    end
    s_ready = 1;
    cycle();
    check("t4_resume_m1", ob_win, 1);
    m1_addr = 32'h388;
    cycle();
    check("t4_resume_m0", ob_win, 0);
    set_idle();
    repeat (4) cycle();

    // Reset one cycle after a read grant discards the response.
    m0_req = 1; m0_addr = 32'h1C0;
    cycle();
    check("t5_gnt", ob_win, 0);
    set_idle();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t5_l2_no_rvalid", ob_rv0[1], 0);
    end
    m0_req = 1; m0_addr = 32'h1C4; m1_req = 1; m1_addr = 32'h3C4;
    cycle();
    check("t5_post_reset_m0", ob_win, 0);
    set_idle();
    repeat (4) cycle();

`ifdef SHARED_ARB_LOCK_EN
    m1_req = 1; m1_addr = 32'h500; m1_lock = 1;
    cycle();
    check("t6_lock_first", ob_win, 1);
    m0_req = 1; m0_addr = 32'h600;
    for (int i = 0; i < 4; i++) begin
      m1_addr += 1;
      cycle();
      check("t6_locked_m1", ob_win, 1);
    end
    m1_lock = 0;
    m1_addr += 1;
    cycle();
    check("t6_unlock_m0", ob_win, 0);
    set_idle();
    repeat (4) cycle();
`endif

    // Randomized traffic, occasional stalls and resets.
    rand_m0();
    rand_m1();
    for (int n = 0; n < 3000; n++) begin
      rstn    = ($urandom % 150) != 0;
      s_ready = ($urandom % 4) != 0;
`ifdef SHARED_ARB_LOCK_EN
      if (($urandom % 8) == 0) m1_lock = ~m1_lock;
`endif
      cycle();
      if (!m0_req || exp_win == 0) rand_m0();
      if (!m1_req || exp_win == 1) rand_m1();
    end
    rstn = 1;
    set_idle();
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Two-requester arbiter for the minion SoC shared-memory port (shared_sel / shared_rdata path).
- Requester 0 is the minion core LSU; requester 1 is a host/debug loader, e.g. a UART-driven loader.
- Round-robin grant; drives a single slave port with fixed read latency.
- Tracks in-flight reads and routes read data back to the owning requester.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 bits wide.
- LATENCY, 1, cycles from slave accept (s_ce high) to s_rdata valid; legal range 1..4.

Ports:
- msoc_clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  synchronous active-low reset.
- m0_req  input  1  requester 0 access request.
- m0_we  input  1  requester 0 write (1) / read (0).
- m0_addr  input  AW  requester 0 word address.
- m0_wdata  input  DW  requester 0 write data.
- m0_be  input  DW/8  requester 0 byte enables.
- m0_gnt  output  1  requester 0 accepted this cycle.
- m0_rvalid  output  1  requester 0 read data valid.
- m0_rdata  output  DW  requester 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for requester 1.
- s_ready  input  1  slave can accept an access this cycle.
- s_ce  output  1  slave access strobe.
- s_we  output  1  slave write.
- s_addr  output  AW  slave address.
- s_wdata  output  DW  slave write data.
- s_be  output  DW/8  slave byte enables.
- s_rdata  input  DW  slave read data, valid LATENCY cycles after an accepted read.

Behaviour:
- Reset (rstn low at a clock edge):
  - last_grant := 1, so requester 0 wins the first tie.
  - Response pipeline cleared.
  - All rvalid outputs low from the next cycle.
- Grant is combinational in the same cycle as the request:
  - No grant while s_ready=0; both gnt low and s_ce=0.
  - s_ready=1 with one request pending: that requester is granted.
  - s_ready=1 with both requesting: grant goes to the requester not equal to last_grant.
  - last_grant updates to the winner on every grant.
- Outputs with no grant:
  - s_ce=0.
  - s_we, s_addr, s_wdata and s_be carry requester 0's fields. They are don't-care for the slave.
  - m*_gnt=0.
- On a grant:
  - s_ce=1.
  - s_we, s_addr, s_wdata and s_be are muxed from the winner.
  - Winner's gnt=1 for exactly that cycle.
  - Requester keeps its fields stable until its gnt is seen. It may issue back-to-back requests, one per cycle.
- Response pipeline:
  - LATENCY-deep shift register of {valid, owner}.
  - valid = s_ce & ~s_we; owner = winner index.
  - Stage LATENCY-1 drives m0_rvalid (valid & owner==0) and m1_rvalid (valid & owner==1).
  - m0_rdata = m1_rdata = s_rdata, passed through combinationally; only meaningful when the matching rvalid is high.
- Writes complete on gnt and produce no rvalid.
- Throughput: one access per cycle; up to LATENCY reads in flight. No backpressure on responses; requesters must always accept rvalid.
- Starvation bound: with continuous contention, each requester is granted at least every 2nd ready cycle.
- s_ready low mid-stream: pending requests stall. In-flight reads still complete on schedule.
- Reset mid-operation: in-flight responses are discarded, no rvalid is emitted for them, and the arbiter returns to the reset state.

Optional Feature:
- Macro SHARED_ARB_LOCK_EN.
- When defined:
  - Adds input m1_lock (1 bit).
  - While m1_lock=1 and last_grant=1, requester 0 is never granted; requester 1 holds exclusive ownership for atomic loader sequences.
  - Requester 0's request stays pending and is granted on the first ready cycle after m1_lock falls (round-robin resumes).
  - m1_lock is ignored while last_grant=0.
- When undefined: the port does not exist and arbitration is pure round-robin.

Test Plan:
- Reset, then m0 read of 0x100 alone with s_ready=1 and LATENCY=1:
  - m0_gnt and s_ce high the same cycle, s_addr=0x100.
  - Next cycle m0_rvalid=1, m0_rdata = slave value 0xDEADBEEF; m1_rvalid stays 0.
- Both requesters read continuously for 6 cycles from reset:
  - Grant order m0,m1,m0,m1,m0,m1.
  - rvalid owners follow the same order delayed by LATENCY.
  - Repeat with LATENCY=3.
- m1 write 0x12345678 to 0x40 with be=0x3 while m0 idle:
  - s_we=1, s_be=0x3, s_wdata=0x12345678 for one cycle.
  - No rvalid on either port.
- s_ready low for 3 cycles with both requesting:
  - No gnt and s_ce=0 throughout; an earlier in-flight read still returns its rvalid.
  - After s_ready rises, grants resume at the correct round-robin position.
- rstn asserted one cycle after a read grant with LATENCY=2:
  - No rvalid is ever emitted for that read.
  - First post-reset contention is granted to m0.
- With SHARED_ARB_LOCK_EN defined:
  - m1 granted with m1_lock=1, both requesting for 4 cycles: m1 granted 4 times, m0 none.
  - Drop m1_lock: next ready cycle grants m0.
